// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART datapath buffers.
package uart_pkg;

  localparam int DEF_DBIT  = 8;
  localparam int DEF_DEPTH = 16;

  // Read-mode encodings for the FWFT parameter.
  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // A pointer into a two-entry buffer still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// Host-facing handshake bundle of the UART FIFO; the FIFO is the slave side.
interface uart_fifo_ctrl_if
  import uart_pkg::*;
#(
  parameter int DBIT  = DEF_DBIT,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CW = $clog2(DEPTH + 1);

  logic            clr;
  logic            wr_en;
  logic [DBIT-1:0] wr_data;
  logic            rd_en;
  logic [DBIT-1:0] rd_data;
  logic            rd_valid;
  logic            empty;
  logic            full;
  logic            almost_empty;
  logic            almost_full;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            underflow;
  logic            err_clr;

  modport master (
    output clr, wr_en, wr_data, rd_en, err_clr,
    input  rd_data, rd_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_2p.sv
// DEPTH x DBIT register file: synchronous write port, asynchronous read port.
module fifo_mem_2p #(
  parameter int DBIT  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DBIT-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DBIT-1:0] rdata_o
);

  logic [DBIT-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Parametrised synchronous FIFO controller for the UART TX/RX paths: pointers,
// occupancy, threshold flags, optional FWFT read, flush and sticky error flags.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT      = DEF_DBIT,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int FWFT      = FWFT_OFF,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  uart_fifo_ctrl_if.slave  bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DBIT-1:0] rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic            empty, full;
  logic            wr_acc, rd_acc;
  logic [DBIT-1:0] mem_rdata;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_FULL);
  assign wr_acc = bus.wr_en & ~full  & ~bus.clr;
  assign rd_acc = bus.rd_en & ~empty & ~bus.clr;

  fifo_mem_2p #(
    .DBIT  (DBIT),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // NOTE: every output of this block takes a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = bus.err_clr ? 1'b0 : overflow_q;
    underflow_d = bus.err_clr ? 1'b0 : underflow_q;

    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) begin
        rd_ptr_d   = ptr_inc(rd_ptr_q);
        rd_data_d  = mem_rdata;
        rd_valid_d = 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // Setting an error flag wins over a same-cycle err_clr.
      if (bus.wr_en && full)  overflow_d  = 1'b1;
      if (bus.rd_en && empty) underflow_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.rd_data      = (FWFT == FWFT_ON) ? mem_rdata : rd_data_q;
  assign bus.rd_valid     = (FWFT == FWFT_ON) ? ~empty    : rd_valid_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (count_q <= CNT_AE);
  assign bus.almost_full  = (count_q >= CNT_AF);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: a 16-deep registered-read FIFO, a 5-deep
// FIFO for pointer wrap, and a 4-deep FWFT FIFO.
module tb_uart_fifo_ctrl;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_fifo_ctrl_if #(.DBIT(8), .DEPTH(16)) b16 ();
  uart_fifo_ctrl_if #(.DBIT(8), .DEPTH(5))  b5  ();
  uart_fifo_ctrl_if #(.DBIT(8), .DEPTH(4))  bfw ();

  uart_fifo_ctrl #(.DBIT(8), .DEPTH(16), .FWFT(FWFT_OFF)) u_d16 (.clk(clk), .rst(rst), .bus(b16));
  uart_fifo_ctrl #(.DBIT(8), .DEPTH(5),  .FWFT(FWFT_OFF)) u_d5  (.clk(clk), .rst(rst), .bus(b5));
  uart_fifo_ctrl #(.DBIT(8), .DEPTH(4),  .FWFT(FWFT_ON))  u_fw  (.clk(clk), .rst(rst), .bus(bfw));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {b16.clr, b16.wr_en, b16.rd_en, b16.err_clr} = '0; b16.wr_data = '0;
    {b5.clr,  b5.wr_en,  b5.rd_en,  b5.err_clr}  = '0; b5.wr_data  = '0;
    {bfw.clr, bfw.wr_en, bfw.rd_en, bfw.err_clr} = '0; bfw.wr_data = '0;

    #12 rst = 1'b0;
    check("rst_empty",    b16.empty, 1);
    check("rst_full",     b16.full, 0);
    check("rst_ae",       b16.almost_empty, 1);
    check("rst_af",       b16.almost_full, 0);
    check("rst_count",    b16.count, 0);
    check("rst_rd_valid", b16.rd_valid, 0);
    check("rst_rd_data",  b16.rd_data, 0);
    check("rst_ovf",      b16.overflow, 0);
    check("rst_udf",      b16.underflow, 0);

    // 16-deep fill with flag thresholds (AF=14, AE=2).
    b16.wr_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      b16.wr_data = 8'(k);
      tick();
      check($sformatf("fill_count%0d", k), b16.count, k);
      check($sformatf("fill_af%0d", k),    b16.almost_full, (k >= 14));
      check($sformatf("fill_ae%0d", k),    b16.almost_empty, (k <= 2));
      check($sformatf("fill_full%0d", k),  b16.full, (k == 16));
    end

    // Overflow is sticky, err_clr clears it, set beats err_clr.
    b16.wr_data = 8'hAA;
    tick();
    b16.wr_en = 1'b0;
    check("ovf_count", b16.count, 16);
    check("ovf_set",   b16.overflow, 1);
    tick();
    check("ovf_sticky", b16.overflow, 1);
    b16.err_clr = 1'b1;
    tick();
    check("ovf_cleared", b16.overflow, 0);
    b16.wr_en = 1'b1;
    tick();
    b16.wr_en = 1'b0;
    check("ovf_set_wins", b16.overflow, 1);
    tick();
    b16.err_clr = 1'b0;
    check("ovf_clear2", b16.overflow, 0);

    // Drain in order with a one-cycle read latency.
    b16.rd_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("drain_valid%0d", k), b16.rd_valid, 1);
      check($sformatf("drain_data%0d", k),  b16.rd_data, k);
      check($sformatf("drain_count%0d", k), b16.count, 16 - k);
    end
    b16.rd_en = 1'b0;
    check("drain_empty", b16.empty, 1);
    tick();
    check("drain_valid_drop", b16.rd_valid, 0);
    check("drain_data_hold",  b16.rd_data, 8'h10);
    check("drain_no_udf",     b16.underflow, 0);

    // Simultaneous write and read at count=3, then at count=0.
    b16.wr_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b16.wr_data = 8'(8'h21 + k);
      tick();
    end
    b16.rd_en   = 1'b1;
    b16.wr_data = 8'h24;
    tick();
    b16.wr_en = 1'b0;
    check("both3_count", b16.count, 3);
    check("both3_valid", b16.rd_valid, 1);
    check("both3_data",  b16.rd_data, 8'h21);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("both3_pop%0d", k), b16.rd_data, 8'h22 + k);
    end
    check("both0_pre_empty", b16.empty, 1);
    b16.wr_en   = 1'b1;
    b16.wr_data = 8'h55;
    tick();
    {b16.wr_en, b16.rd_en} = 2'b00;
    check("both0_count", b16.count, 1);
    check("both0_valid", b16.rd_valid, 0);
    check("both0_hold",  b16.rd_data, 8'h24);
    check("both0_udf",   b16.underflow, 1);

    // Fill, overflow, back off to 7, then flush together with a write.
    b16.wr_en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      b16.wr_data = 8'(8'h60 + k);
      tick();
    end
    check("f6_full", b16.full, 1);
    tick();
    b16.wr_en = 1'b0;
    check("f6_ovf", b16.overflow, 1);
    b16.rd_en = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    b16.rd_en = 1'b0;
    check("f6_count7", b16.count, 7);
    b16.clr   = 1'b1;
    b16.wr_en = 1'b1;
    tick();
    {b16.clr, b16.wr_en} = 2'b00;
    check("clr_count", b16.count, 0);
    check("clr_empty", b16.empty, 1);
    check("clr_valid", b16.rd_valid, 0);
    check("clr_ovf",   b16.overflow, 1);
    check("clr_udf",   b16.underflow, 1);

    // DEPTH=5: fill to full, drain, then 12 write/read pairs across the wrap.
    b5.wr_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b5.wr_data = 8'(8'h40 + k);
      tick();
    end
    b5.wr_en = 1'b0;
    check("d5_full",  b5.full, 1);
    check("d5_count", b5.count, 5);
    b5.rd_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("d5_drain%0d", k), b5.rd_data, 8'h40 + k);
    end
    b5.rd_en = 1'b0;
    check("d5_empty", b5.empty, 1);
    for (int i = 0; i < 12; i++) begin
      b5.wr_en   = 1'b1;
      b5.wr_data = 8'(8'h30 + i);
      tick();
      b5.wr_en = 1'b0;
      b5.rd_en = 1'b1;
      tick();
      b5.rd_en = 1'b0;
      check($sformatf("d5_pair%0d", i), b5.rd_data, 8'h30 + i);
      check($sformatf("d5_pair_count%0d", i), b5.count, 0);
    end

    // FWFT: head word shows without a read request.
    check("fw_rst_valid", bfw.rd_valid, 0);
    bfw.wr_en   = 1'b1;
    bfw.wr_data = 8'h5A;
    tick();
    bfw.wr_data = 8'h5B;
    check("fw_head",  bfw.rd_data, 8'h5A);
    check("fw_valid", bfw.rd_valid, 1);
    tick();
    bfw.wr_en = 1'b0;
    check("fw_head_kept", bfw.rd_data, 8'h5A);
    bfw.rd_en = 1'b1;
    tick();
    check("fw_next", bfw.rd_data, 8'h5B);
    check("fw_next_valid", bfw.rd_valid, 1);
    tick();
    bfw.rd_en = 1'b0;
    check("fw_empty", bfw.empty, 1);
    check("fw_valid_drop", bfw.rd_valid, 0);

    // Asynchronous reset mid-burst drops a pending rd_valid at once.
    b16.wr_en   = 1'b1;
    b16.wr_data = 8'h77;
    for (int k = 0; k < 3; k++) tick();
    b16.rd_en = 1'b1;
    tick();
    check("mid_pre_valid", b16.rd_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_count",    b16.count, 0);
    check("mid_empty",    b16.empty, 1);
    check("mid_full",     b16.full, 0);
    check("mid_ae",       b16.almost_empty, 1);
    check("mid_af",       b16.almost_full, 0);
    check("mid_valid",    b16.rd_valid, 0);
    check("mid_rd_data",  b16.rd_data, 0);
    check("mid_ovf",      b16.overflow, 0);
    check("mid_udf",      b16.underflow, 0);
    {b16.wr_en, b16.rd_en} = 2'b00;
    #2 rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
